instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream stage of the microprocessor top: holds a small loadable program store and a program counter, and drives the 32-bit instruction word consumed by the processor top each clock.
- A host loads instructions through a ready/enable handshake, then starts the run. The unit issues one instruction per cycle until the program ends or a halt is requested.
- When nothing is being issued it drives an all-zero bubble. Opcode 0 lies outside the executable range 4..14, so the processor's register-file write enable stays off for bubbles.

Parameters:
- DEPTH, 16, number of instruction slots in the program store (power of two)
- AW, 4, address width, log2(DEPTH)

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- load_en  input  1  host offers load_data this cycle
- load_data  input  32  instruction word to append to the program
- load_ready  output  1  store can accept a word (IDLE and not full)
- start  input  1  begin or restart execution from slot 0
- halt_req  input  1  abort the current run
- clear  input  1  discard the loaded program
- instruction  output  32  registered instruction word to the processor top; 0 when no instruction is issued
- instr_valid  output  1  instruction holds a real program word this cycle
- pc  output  AW  slot index of the next word to issue
- prog_len  output  AW+1  number of words loaded, 0..DEPTH
- busy  output  1  state is RUN
- done  output  1  state is DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; instruction=0; instr_valid=0; pc=0; prog_len=0; busy=0; done=0. Store contents are not reset; they are unreachable because prog_len=0.
- States: IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE.
- load_ready = (state==IDLE) && (prog_len<DEPTH), combinational.
- Load: on an edge with load_en && load_ready, mem[prog_len]<=load_data and prog_len<=prog_len+1.
  - load_en while load_ready=0 (full, RUN or DONE) is ignored with no side effects.
- clear: accepted only in IDLE or DONE. Sets prog_len<=0, pc<=0 and state<=IDLE. clear in RUN is ignored.
- Priority in IDLE: clear > load > start.
  - start with load_en accepted in the same cycle is ignored.
  - start with prog_len==0 is ignored and the state stays IDLE.
- IDLE->RUN on start with prog_len>0. At that edge: instruction<=mem[0], instr_valid<=1, pc<=1.
  - Latency: the first word is visible immediately after the start edge and is sampled by the processor at the next edge.
- RUN, each edge:
  - If pc<prog_len: instruction<=mem[pc], instr_valid<=1, pc<=pc+1.
  - If pc==prog_len (the last word was issued on the previous edge): instruction<=0, instr_valid<=0, state<=DONE.
  - Exactly prog_len consecutive valid cycles per run, no gaps.
- halt_req in RUN: at the next edge instruction<=0, instr_valid<=0, state<=DONE, and pc holds its value (the index of the first unissued word). halt_req outside RUN is ignored.
- halt_req takes priority over normal issue. halt_req together with start in RUN: halt wins.
- DONE: outputs bubble.
  - start (prog_len>0) re-enters RUN exactly as from IDLE, rerunning the same program from slot 0.
  - clear returns to IDLE.
  - start and clear together: clear wins.
- pc width: pc counts 0..prog_len but is an AW-bit output. When DEPTH words are loaded, pc wraps to 0 after the last issue. The end-of-run test must therefore use an internal AW+1-bit issue count, not pc. The RUN->DONE transition must still occur after exactly DEPTH words.
- The unit does no opcode decoding. Illegal opcodes are passed through unchanged with instr_valid=1.
- Reset mid-run: all outputs go to their reset values immediately (asynchronously). After release, the unit is in IDLE with an empty program.

Test Plan:
- Load 3 words 32'h0001_0884, 32'h0002_1085, 32'h0003_18C6, then pulse start -> instruction shows these three words on 3 consecutive cycles with instr_valid=1, then 0 with instr_valid=0; done=1 and prog_len=3.
- Load 16 words (0x100+i), then attempt a 17th (0xDEAD) -> load_ready drops after the 16th word, 0xDEAD is dropped, and prog_len=16. Run -> exactly 16 valid cycles, pc wraps to 0, and DONE is reached.
- Load 8 words, start, assert halt_req on the 3rd issue cycle -> instruction=0 on the next cycle, done=1, pc=3. Then start -> the run restarts with mem[0].
- Assert start and load_en in the same IDLE cycle with prog_len=2 -> the word is stored (prog_len=3) and the state stays IDLE. Also: start with prog_len=0 -> no transition.
- Drop rst_n low mid-run (in the middle of the clock period) -> instruction=0, instr_valid=0 and busy=0 before the next edge. After release, prog_len=0 and load_ready=1.
- In DONE, assert start and clear together -> state returns to IDLE, prog_len=0, and no instruction is issued.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: loadable program store plus program counter that
// issues one registered 32-bit instruction word per cycle, with bubbles of zero.
module instr_fetch_unit #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [31:0]   load_data,
    output logic          load_ready,
    input  logic          start,
    input  logic          halt_req,
    input  logic          clear,
    output logic [31:0]   instruction,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic [AW:0]   prog_len,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [31:0]   mem [DEPTH];
    logic [AW:0]   issue_cnt, issue_cnt_n;
    logic [AW:0]   prog_len_n;
    logic [AW-1:0] pc_n;
    logic [31:0]   instruction_n;
    logic          instr_valid_n;
    logic          mem_we;

    assign load_ready = (state == IDLE) && (prog_len < (AW+1)'(DEPTH));
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

    // pc wraps when the store is full, so the end-of-run test uses issue_cnt.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_n       = state;
        pc_n          = pc;
        issue_cnt_n   = issue_cnt;
        prog_len_n    = prog_len;
        instruction_n = 32'd0;
        instr_valid_n = 1'b0;
        mem_we        = 1'b0;

        unique case (state)
            IDLE: begin
                if (clear) begin
                    prog_len_n  = '0;
                    pc_n        = '0;
                    issue_cnt_n = '0;
                end else if (load_en && load_ready) begin
                    mem_we     = 1'b1;
                    prog_len_n = prog_len + (AW+1)'(1);
                end else if (start && (prog_len != '0)) begin
                    state_n       = RUN;
                    instruction_n = mem[0];
                    instr_valid_n = 1'b1;
                    pc_n          = AW'(1);
                    issue_cnt_n   = (AW+1)'(1);
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_n = DONE;
                end else if (issue_cnt < prog_len) begin
                    instruction_n = mem[pc];
                    instr_valid_n = 1'b1;
                    pc_n          = pc + AW'(1);
                    issue_cnt_n   = issue_cnt + (AW+1)'(1);
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (clear) begin
                    state_n     = IDLE;
                    prog_len_n  = '0;
                    pc_n        = '0;
                    issue_cnt_n = '0;
                end else if (start && (prog_len != '0)) begin
                    state_n       = RUN;
                    instruction_n = mem[0];
                    instr_valid_n = 1'b1;
                    pc_n          = AW'(1);
                    issue_cnt_n   = (AW+1)'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            issue_cnt   <= '0;
            prog_len    <= '0;
            instruction <= 32'd0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            issue_cnt   <= issue_cnt_n;
            prog_len    <= prog_len_n;
            instruction <= instruction_n;
            instr_valid <= instr_valid_n;
        end
    end

    // NOTE: the store has no reset; stale words are unreachable while prog_len is 0.
    always_ff @(posedge clk) begin
        if (mem_we) mem[prog_len[AW-1:0]] <= load_data;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// traffic, compared every cycle against a queue-based program model.
module tb_instr_fetch_unit;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_en = 1'b0;
    logic [31:0]   load_data = '0;
    logic          load_ready;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic          clear = 1'b0;
    logic [31:0]   instruction;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic [AW:0]   prog_len;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_data(load_data),
        .load_ready(load_ready), .start(start), .halt_req(halt_req), .clear(clear),
        .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
        .prog_len(prog_len), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the loaded program as a list, the words still to issue in this run,
    // and how many have been issued so far.
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    logic [31:0] m_prog[$];
    logic [31:0] m_pending[$];
    int          m_mode = M_IDLE;
    int          m_issued = 0;
    logic [31:0] m_instr = '0;
    logic        m_valid = 1'b0;

    task automatic m_begin_run();
        m_pending = m_prog;
        m_instr   = m_pending.pop_front();
        m_valid   = 1'b1;
        m_issued  = 1;
        m_mode    = M_RUN;
    endtask

    always @(negedge rst_n) begin
        m_prog.delete();
        m_pending.delete();
        m_mode = M_IDLE; m_issued = 0; m_instr = '0; m_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            m_instr = '0;
            m_valid = 1'b0;
            if (m_mode == M_RUN) begin
                if (halt_req) m_mode = M_DONE;
                else if (m_pending.size() > 0) begin
                    m_instr = m_pending.pop_front();
                    m_valid = 1'b1;
                    m_issued++;
                end else m_mode = M_DONE;
            end else if (clear) begin
                m_prog.delete();
                m_issued = 0;
                m_mode = M_IDLE;
            end else if (m_mode == M_IDLE && load_en && m_prog.size() < DEPTH) begin
                m_prog.push_back(load_data);
            end else if (start && m_prog.size() > 0) begin
                m_begin_run();
            end
        end
    end

    always @(negedge clk) begin
        check("instruction", 64'(instruction), 64'(m_instr));
        check("instr_valid", 64'(instr_valid), 64'(m_valid));
        check("pc", 64'(pc), 64'(m_issued % DEPTH));
        check("prog_len", 64'(prog_len), 64'(m_prog.size()));
        check("busy", 64'(busy), 64'(m_mode == M_RUN));
        check("done", 64'(done), 64'(m_mode == M_DONE));
        check("load_ready", 64'(load_ready), 64'(m_mode == M_IDLE && m_prog.size() < DEPTH));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load_word(input logic [31:0] w);
        load_en = 1'b1; load_data = w; step(); load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic wait_done(output int nvalid);
        int cyc = 0;
        nvalid = 0;
        while (!done && cyc < 64) begin
            if (instr_valid) nvalid++;
            step();
            cyc++;
        end
        if (!done) check("run_timeout", 64'(done), 64'd1);
    endtask

    logic [31:0] words3 [3];
    int nv;

    initial begin
        words3[0] = 32'h0001_0884; words3[1] = 32'h0002_1085; words3[2] = 32'h0003_18C6;
        step(); step();
        rst_n = 1'b1;
        step();
        check("reset_prog_len", 64'(prog_len), 64'd0);
        check("reset_load_ready", 64'(load_ready), 64'd1);

        // Three-word program
        for (int i = 0; i < 3; i++) load_word(words3[i]);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            check("run3_word", 64'(instruction), 64'(words3[i]));
            check("run3_valid", 64'(instr_valid), 64'd1);
            step();
        end
        check("run3_bubble", 64'(instruction), 64'd0);
        check("run3_done", 64'(done), 64'd1);
        check("run3_len", 64'(prog_len), 64'd3);

        // Full store, overflow word dropped, wrap of pc
        pulse_clear();
        for (int i = 0; i < DEPTH; i++) load_word(32'h100 + 32'(i));
        check("full_ready", 64'(load_ready), 64'd0);
        load_word(32'hDEAD);
        check("full_len", 64'(prog_len), 64'd16);
        pulse_start();
        wait_done(nv);
        check("full_valid_cycles", 64'(nv), 64'd16);
        check("full_pc_wrap", 64'(pc), 64'd0);

        // Halt on the third issue cycle, then restart
        pulse_clear();
        for (int i = 0; i < 8; i++) load_word(32'hA000 + 32'(i));
        pulse_start();
        step(); step();
        check("halt_third", 64'(instruction), 64'hA002);
        halt_req = 1'b1; step(); halt_req = 1'b0;
        check("halt_bubble", 64'(instruction), 64'd0);
        check("halt_done", 64'(done), 64'd1);
        check("halt_pc", 64'(pc), 64'd3);
        pulse_start();
        check("restart_word0", 64'(instruction), 64'hA000);
        wait_done(nv);

        // start together with an accepted load, and start on an empty store
        pulse_clear();
        load_word(32'h11); load_word(32'h22);
        load_en = 1'b1; load_data = 32'h33; start = 1'b1; step();
        load_en = 1'b0; start = 1'b0;
        check("ld_start_len", 64'(prog_len), 64'd3);
        check("ld_start_busy", 64'(busy), 64'd0);
        pulse_clear();
        pulse_start();
        check("empty_start_busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-run
        for (int i = 0; i < 3; i++) load_word(words3[i]);
        pulse_start();
        @(posedge clk); #2 rst_n = 1'b0; #1;
        check("arst_instr", 64'(instruction), 64'd0);
        check("arst_valid", 64'(instr_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        step(); rst_n = 1'b1; step();
        check("arst_len", 64'(prog_len), 64'd0);
        check("arst_ready", 64'(load_ready), 64'd1);

        // start and clear together in DONE
        load_word(32'h7); load_word(32'h8);
        pulse_start();
        wait_done(nv);
        start = 1'b1; clear = 1'b1; step(); start = 1'b0; clear = 1'b0;
        check("sc_busy", 64'(busy), 64'd0);
        check("sc_done", 64'(done), 64'd0);
        check("sc_len", 64'(prog_len), 64'd0);
        step();
        check("sc_valid", 64'(instr_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            load_en   = ($urandom_range(0, 99) < 35);
            load_data = $urandom();
            start     = ($urandom_range(0, 99) < 8);
            halt_req  = ($urandom_range(0, 99) < 4);
            clear     = ($urandom_range(0, 99) < 3);
            step();
        end
        load_en = 1'b0; start = 1'b0; halt_req = 1'b0; clear = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
